// File: rtl/fir_cfg_seq.sv
// fir_cfg_seq: AXI-Lite master that programs and launches the fir block.
// Sequence per run: write data_length, write all taps, read every tap back
// and compare, write ap_start, then poll ap_done with a fixed idle gap.
// Every run ends with a one-cycle done pulse. Errors are reported through
// the sticky err/err_code pair.
module fir_cfg_seq #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11,
  parameter int pIDX_WIDTH  = 4,
  parameter int pPOLL_GAP   = 8,
  parameter int pTIMEOUT    = 1024
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   start,
  input  logic [31:0]            data_length,
  output logic [pIDX_WIDTH-1:0]  coef_idx,
  input  logic [31:0]            coef_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic                   awvalid,
  output logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   awready,
  output logic                   wvalid,
  output logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   wready,
  output logic                   arvalid,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   arready,
  input  logic                   rvalid,
  input  logic [pDATA_WIDTH-1:0] rdata,
  output logic                   rready
);

  localparam int TW = $clog2(pTIMEOUT + 1);
  localparam int GW = (pPOLL_GAP > 1) ? $clog2(pPOLL_GAP) : 1;

  localparam logic [TW-1:0]          TO_LAST  = TW'(pTIMEOUT - 1);
  localparam logic [GW-1:0]          GAP_LAST = GW'(pPOLL_GAP - 1);
  localparam logic [pIDX_WIDTH-1:0]  IDX_LAST = pIDX_WIDTH'(Tape_Num - 1);

  localparam logic [pADDR_WIDTH-1:0] A_CTRL = '0;
  localparam logic [pADDR_WIDTH-1:0] A_LEN  = pADDR_WIDTH'(16);
  localparam logic [pADDR_WIDTH-1:0] A_COEF = pADDR_WIDTH'(32);

  localparam logic [1:0] E_NONE = 2'd0;
  localparam logic [1:0] E_MISM = 2'd1;
  localparam logic [1:0] E_TOUT = 2'd2;
  localparam logic [1:0] E_ZLEN = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_LEN, S_WR_COEF, S_RD_COEF,
    S_WR_START, S_POLL_GAP, S_POLL_RD, S_FINISH
  } state_t;

  state_t r_state, w_nxt;

  // bus channel registers
  logic                   r_act;       // a transaction is outstanding
  logic                   r_awvalid, r_wvalid, r_arvalid, r_rready;
  logic                   r_aw_done, r_w_done;
  logic [pADDR_WIDTH-1:0] r_awaddr, r_araddr;
  logic [pDATA_WIDTH-1:0] r_wdata;
  logic [TW-1:0]          r_tcnt;
  logic [GW-1:0]          r_gap;
  logic [pIDX_WIDTH-1:0]  r_idx;
  logic [31:0]            r_len;
  logic                   r_err;
  logic [1:0]             r_err_code;

  // control strobes from the FSM
  logic                   w_launch_wr, w_launch_rd, w_abort;
  logic [pADDR_WIDTH-1:0] w_addr;
  logic [pDATA_WIDTH-1:0] w_wdat;
  logic                   w_idx_clr, w_idx_inc, w_accept, w_err_set;
  logic [1:0]             w_err_code;

  // handshake decode
  logic w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;
  logic w_is_rd, w_wr_both, w_cmpl, w_to, w_idx_last, w_mism;
  logic [pADDR_WIDTH-1:0] w_coef_addr;

  assign w_aw_hs     = r_awvalid & awready;
  assign w_w_hs      = r_wvalid & wready;
  assign w_ar_hs     = r_arvalid & arready;
  assign w_r_hs      = r_rready & rvalid;
  assign w_is_rd     = (r_state == S_RD_COEF) || (r_state == S_POLL_RD);
  assign w_wr_both   = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
  assign w_cmpl      = r_act & (w_is_rd ? w_r_hs : w_wr_both);
  assign w_to        = r_act & (r_tcnt == TO_LAST) & ~w_cmpl;
  assign w_idx_last  = (r_idx == IDX_LAST);
  assign w_coef_addr = A_COEF + pADDR_WIDTH'(r_idx);
  assign w_mism      = (rdata != pDATA_WIDTH'(coef_data));

  // state register
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  // next-state and per-cycle control strobes
  always_comb begin
    w_nxt       = r_state;
    w_launch_wr = 1'b0;
    w_launch_rd = 1'b0;
    w_abort     = 1'b0;
    w_addr      = '0;
    w_wdat      = '0;
    w_idx_clr   = 1'b0;
    w_idx_inc   = 1'b0;
    w_accept    = 1'b0;
    w_err_set   = 1'b0;
    w_err_code  = E_NONE;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (data_length == 32'd0) begin
            w_err_set  = 1'b1;
            w_err_code = E_ZLEN;
            w_nxt      = S_FINISH;
          end else begin
            w_accept = 1'b1;
            w_nxt    = S_WR_LEN;
          end
        end
      end
      S_WR_LEN: begin
        if (!r_act) begin
          w_launch_wr = 1'b1;
          w_addr      = A_LEN;
          w_wdat      = pDATA_WIDTH'(r_len);
        end else if (w_cmpl) begin
          w_idx_clr = 1'b1;
          w_nxt     = S_WR_COEF;
        end
      end
      S_WR_COEF: begin
        if (!r_act) begin
          w_launch_wr = 1'b1;
          w_addr      = w_coef_addr;
          w_wdat      = pDATA_WIDTH'(coef_data);
        end else if (w_cmpl) begin
          if (w_idx_last) begin
            w_idx_clr = 1'b1;
            w_nxt     = S_RD_COEF;
          end else begin
            w_idx_inc = 1'b1;
          end
        end
      end
      S_RD_COEF: begin
        if (!r_act) begin
          w_launch_rd = 1'b1;
          w_addr      = w_coef_addr;
        end else if (w_cmpl) begin
          if (w_mism) begin
            w_err_set  = 1'b1;
            w_err_code = E_MISM;
            w_nxt      = S_FINISH;
          end else if (w_idx_last) begin
            w_nxt = S_WR_START;
          end else begin
            w_idx_inc = 1'b1;
          end
        end
      end
      S_WR_START: begin
        if (!r_act) begin
          w_launch_wr = 1'b1;
          w_addr      = A_CTRL;
          w_wdat      = pDATA_WIDTH'(1);
        end else if (w_cmpl) begin
          w_nxt = S_POLL_GAP;
        end
      end
      S_POLL_GAP: begin
        // launch the status read directly so the gap is exactly pPOLL_GAP cycles
        if (r_gap == GAP_LAST) begin
          w_launch_rd = 1'b1;
          w_addr      = A_CTRL;
          w_nxt       = S_POLL_RD;
        end
      end
      S_POLL_RD: begin
        if (w_cmpl) w_nxt = rdata[1] ? S_FINISH : S_POLL_GAP;
      end
      S_FINISH: w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
    // a stuck transaction overrides whatever the state wanted to do
    if (w_to) begin
      w_launch_wr = 1'b0;
      w_launch_rd = 1'b0;
      w_idx_clr   = 1'b0;
      w_idx_inc   = 1'b0;
      w_abort     = 1'b1;
      w_err_set   = 1'b1;
      w_err_code  = E_TOUT;
      w_nxt       = S_FINISH;
    end
  end

  // AXI-Lite channel valids/ready, addresses and write data
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_act     <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_araddr  <= '0;
    end else if (w_abort) begin
      r_act     <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
    end else if (w_launch_wr) begin
      r_act     <= 1'b1;
      r_awvalid <= 1'b1;
      r_wvalid  <= 1'b1;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_awaddr  <= w_addr;
      r_wdata   <= w_wdat;
    end else if (w_launch_rd) begin
      r_act     <= 1'b1;
      r_arvalid <= 1'b1;
      r_rready  <= 1'b1;
      r_araddr  <= w_addr;
    end else begin
      if (w_aw_hs) begin
        r_awvalid <= 1'b0;
        r_aw_done <= 1'b1;
      end
      if (w_w_hs) begin
        r_wvalid <= 1'b0;
        r_w_done <= 1'b1;
      end
      if (w_ar_hs) r_arvalid <= 1'b0;
      if (w_r_hs) begin
        r_rready  <= 1'b0;
        r_arvalid <= 1'b0;
      end
      if (w_cmpl) r_act <= 1'b0;
    end
  end

  // per-transaction timeout counter, restarted at every launch
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst)                        r_tcnt <= '0;
    else if (w_launch_wr || w_launch_rd) r_tcnt <= '0;
    else if (r_act)                      r_tcnt <= r_tcnt + TW'(1);
  end

  // idle cycles spent in POLL_GAP; zero whenever we are elsewhere
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst)                    r_gap <= '0;
    else if (r_state == S_POLL_GAP)  r_gap <= r_gap + GW'(1);
    else                             r_gap <= '0;
  end

  // coefficient index; holds the last tap after the readback loop
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst)       r_idx <= '0;
    else if (w_idx_clr) r_idx <= '0;
    else if (w_idx_inc) r_idx <= r_idx + pIDX_WIDTH'(1);
  end

  // latched length and sticky error status
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_len      <= '0;
      r_err      <= 1'b0;
      r_err_code <= E_NONE;
    end else if (w_accept) begin
      r_len      <= data_length;
      r_err      <= 1'b0;
      r_err_code <= E_NONE;
    end else if (w_err_set) begin
      r_err      <= 1'b1;
      r_err_code <= w_err_code;
    end
  end

  assign coef_idx = r_idx;
  assign busy     = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign done     = (r_state == S_FINISH);
  assign err      = r_err;
  assign err_code = r_err_code;
  assign awvalid  = r_awvalid;
  assign awaddr   = r_awaddr;
  assign wvalid   = r_wvalid;
  assign wdata    = r_wdata;
  assign arvalid  = r_arvalid;
  assign araddr   = r_araddr;
  assign rready   = r_rready;

endmodule

// File: tb/tb_fir_cfg_seq.sv
// Directed bench for fir_cfg_seq: a small AXI-Lite slave model with
// configurable ready skew, a blocked read address, a corrupted readback
// and ap_done on the Nth status poll.
module tb_fir_cfg_seq;
  localparam int AW = 12, DW = 32, NT = 11, IW = 4, GAP = 8, TO = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   data_length = '0;
  logic [IW-1:0] coef_idx;
  logic [31:0]   coef_data;
  logic          busy, done, err;
  logic [1:0]    err_code;
  logic          awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, rdata;

  fir_cfg_seq #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT), .pIDX_WIDTH(IW),
                .pPOLL_GAP(GAP), .pTIMEOUT(TO)) dut (
    .axis_clk(clk), .axis_rst(rst), .start(start), .data_length(data_length),
    .coef_idx(coef_idx), .coef_data(coef_data), .busy(busy), .done(done),
    .err(err), .err_code(err_code), .awvalid(awvalid), .awaddr(awaddr),
    .awready(awready), .wvalid(wvalid), .wdata(wdata), .wready(wready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready), .rvalid(rvalid),
    .rdata(rdata), .rready(rready));

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;

  // local coefficient store
  logic [31:0] coef [0:15];
  assign coef_data = coef[coef_idx];

  // slave knobs, written only by the stimulus block
  int            aw_dly = 0, w_dly = 0, done_poll = 3;
  logic          ar_blk_en = 1'b0;
  logic [AW-1:0] blk_addr = '0, bad_addr = 12'hFFF;
  logic [31:0]   bad_val = '0;

  // slave state and logs
  int            aw_cnt, w_cnt;
  logic          aw_seen, w_seen, s_rvalid;
  logic [AW-1:0] aw_lat;
  logic [31:0]   w_lat, s_rdata;
  logic [31:0]   smem [0:63];
  logic [43:0]   wlog[$];
  logic [AW-1:0] rlog[$];
  int            poll_rise[$];
  int            done_total = 0;
  logic          prev_ar = 1'b0;

  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid && (w_cnt >= w_dly);
  assign arready = arvalid && !(ar_blk_en && araddr == blk_addr);
  assign rvalid  = s_rvalid;
  assign rdata   = s_rdata;

  function automatic int npolls();
    int n = 0;
    foreach (rlog[i]) if (rlog[i] == '0) n++;
    return n;
  endfunction

  // slave model: logs completed writes and serves reads one cycle after AR
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; aw_seen <= 1'b0; w_seen <= 1'b0;
      aw_lat <= '0; w_lat <= '0; s_rvalid <= 1'b0; s_rdata <= '0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      if (awvalid && awready) begin aw_seen <= 1'b1; aw_lat <= awaddr; end
      if (wvalid && wready) begin w_seen <= 1'b1; w_lat <= wdata; end
      if ((aw_seen || (awvalid && awready)) && (w_seen || (wvalid && wready))) begin
        wlog.push_back({((awvalid && awready) ? awaddr : aw_lat),
                        ((wvalid && wready) ? wdata : w_lat)});
        smem[((awvalid && awready) ? awaddr[5:0] : aw_lat[5:0])] <=
          ((wvalid && wready) ? wdata : w_lat);
        aw_seen <= 1'b0;
        w_seen  <= 1'b0;
      end
      if (arvalid && arready) begin
        s_rvalid <= 1'b1;
        s_rdata  <= (araddr == '0) ? ((npolls() + 1 >= done_poll) ? 32'h2 : 32'h0) :
                    (araddr == bad_addr) ? bad_val : smem[araddr[5:0]];
        rlog.push_back(araddr);
      end else if (s_rvalid && rready) begin
        s_rvalid <= 1'b0;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: done pulses and rising edges of status-poll reads
  always @(negedge clk) begin
    if (done) done_total <= done_total + 1;
    if (arvalid && !prev_ar && araddr == '0) poll_rise.push_back(cyc);
    prev_ar <= arvalid;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [31:0] len);
    data_length = len;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  function automatic logic [43:0] wexp(input int i, input logic [31:0] len);
    if (i == 0)       return {12'h010, len};
    else if (i <= NT) return {12'h020 + 12'(i - 1), coef[i-1]};
    else              return {12'h000, 32'h1};
  endfunction

  int wb, rb, pb, db, n0, cnt;
  bit ok;
  int ctab [0:10] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  initial begin
    for (int i = 0; i < 16; i++) coef[i] = (i < NT) ? 32'(ctab[i]) : 32'h0;

    // ---- reset state
    repeat (3) @(negedge clk);
    chk("rst_ctl", {60'h0, awvalid, wvalid, arvalid, rready}, 64'h0);
    chk("rst_sts", {busy, done, err, err_code, coef_idx}, 64'h0);
    chk("rst_bus", {awaddr, wdata, araddr}, 64'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ---- normal run; a start while busy must be ignored
    wb = wlog.size(); rb = rlog.size(); pb = poll_rise.size(); db = done_total;
    pulse_start(600);
    repeat (3) @(negedge clk);
    chk("norm_busy", busy, 1);
    pulse_start(0);
    wait_done(1000, ok);
    chk("norm_done_seen", ok, 1);
    chk("norm_busy_at_done", busy, 0);
    chk("norm_err", {err, err_code}, 0);
    @(negedge clk);
    chk("norm_done_pulse", {done, 32'(done_total - db)}, 64'h1);
    chk("norm_nwr", wlog.size() - wb, NT + 2);
    for (int i = 0; i < NT + 2; i++)
      chk($sformatf("norm_wr%0d", i), (wb + i < wlog.size()) ? wlog[wb + i] : '1, wexp(i, 600));
    chk("norm_nrd", rlog.size() - rb, NT + 3);
    for (int i = 0; i < NT + 3; i++)
      chk($sformatf("norm_rd%0d", i), (rb + i < rlog.size()) ? rlog[rb + i] : '1,
          (i < NT) ? 12'h020 + 12'(i) : 12'h000);
    chk("norm_npoll", poll_rise.size() - pb, 3);
    // 1 AR cycle + 1 R cycle + pPOLL_GAP idle cycles between poll launches
    for (int i = 1; i < 3; i++)
      chk($sformatf("norm_pollgap%0d", i),
          (pb + i < poll_rise.size()) ? poll_rise[pb + i] - poll_rise[pb + i - 1] : -1, GAP + 2);

    // ---- readback mismatch at 0x25
    bad_addr = 12'h025; bad_val = 32'd64;
    wb = wlog.size(); rb = rlog.size(); db = done_total;
    pulse_start(600);
    wait_done(1000, ok);
    chk("mism_done_seen", ok, 1);
    chk("mism_err", {err, err_code}, {1'b1, 2'd1});
    @(negedge clk);
    chk("mism_done_pulse", done_total - db, 1);
    chk("mism_nwr", wlog.size() - wb, NT + 1);
    n0 = 0;
    for (int i = wb; i < wlog.size(); i++) if (wlog[i][43:32] == 12'h000) n0++;
    chk("mism_no_start", n0, 0);
    chk("mism_nrd", rlog.size() - rb, 6);
    chk("mism_last_rd", (rlog.size() > 0) ? rlog[rlog.size() - 1] : '1, 12'h025);
    bad_addr = 12'hFFF;

    // ---- skewed write ready on the first write; err cleared by accept
    aw_dly = 3; w_dly = 0;
    wb = wlog.size();
    pulse_start(100);
    chk("skew_err_clr", {err, err_code}, 0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (awvalid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("skew_aw_seen", ok, 1);
    chk("skew_c0", {awvalid, wvalid}, 2'b11);
    @(negedge clk);
    chk("skew_c1", {awvalid, wvalid, 32'(wlog.size() - wb)}, {2'b10, 32'd0});
    repeat (2) @(negedge clk);
    chk("skew_c3", {awvalid, wvalid}, 2'b10);
    @(negedge clk);
    chk("skew_c4", {awvalid, wvalid, 32'(wlog.size() - wb)}, {2'b00, 32'd1});
    chk("skew_entry", (wb < wlog.size()) ? wlog[wb] : '1, {12'h010, 32'd100});
    aw_dly = 0;
    @(negedge clk);
    chk("skew_next", {awvalid, awaddr}, {1'b1, 12'h020});
    wait_done(1000, ok);
    chk("skew_done", {ok, err, err_code}, {1'b1, 3'b000});
    @(negedge clk);

    // ---- timeout on the read of 0x22
    ar_blk_en = 1'b1; blk_addr = 12'h022;
    pulse_start(600);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (arvalid && araddr == 12'h022) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("to_ar_seen", ok, 1);
    cnt = 0;
    while (arvalid && cnt < 2000) begin cnt++; @(negedge clk); end
    chk("to_len", cnt, TO);
    chk("to_state", {done, arvalid, rready, err, err_code}, {1'b1, 1'b0, 1'b0, 1'b1, 2'd2});
    ar_blk_en = 1'b0;
    @(negedge clk);

    // ---- zero length: done on the cycle after start, no traffic
    wb = wlog.size(); rb = rlog.size();
    pulse_start(0);
    chk("zl_state", {done, busy, err, err_code, awvalid, wvalid, arvalid},
        {1'b1, 1'b0, 1'b1, 2'd3, 3'b000});
    @(negedge clk);
    chk("zl_pulse", {done, 32'(wlog.size() - wb), 32'(rlog.size() - rb)}, 64'h0);

    // ---- async reset during WR_COEF k=5, then a fresh run
    pulse_start(600);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (awvalid && awaddr == 12'h025) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("rm_found", ok, 1);
    #1 rst = 1'b1;
    #1;
    chk("rm_ctl", {busy, done, err, err_code, awvalid, wvalid, arvalid, rready, coef_idx}, 64'h0);
    chk("rm_bus", {awaddr, wdata, araddr}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wb = wlog.size();
    pulse_start(777);
    wait_done(1000, ok);
    chk("rm_rerun", {ok, err, err_code}, {1'b1, 3'b000});
    chk("rm_nwr", wlog.size() - wb, NT + 2);
    chk("rm_first", (wb < wlog.size()) ? wlog[wb] : '1, {12'h010, 32'd777});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_cfg_seq.md
Name: fir_cfg_seq

Overview:
- AXI-Lite master sequencer that programs and launches the fir block without a host.
- On a start pulse it writes data_length to 0x10, then coefficients to 0x20+k, then reads back and verifies every coefficient.
- It then writes ap_start to 0x00 and polls 0x00 until ap_done is set.
- Sits between a local coefficient store (indexed lookup) and the fir AXI-Lite slave port.

Parameters:
- pADDR_WIDTH, 12, AXI-Lite address width.
- pDATA_WIDTH, 32, AXI-Lite data width.
- Tape_Num, 11, number of coefficients programmed.
- pIDX_WIDTH, 4, width of coef_idx; must satisfy 2^pIDX_WIDTH >= Tape_Num.
- pPOLL_GAP, 8, idle cycles between successive status polls.
- pTIMEOUT, 1024, maximum cycles any single AXI-Lite transaction may stay outstanding.

Ports:
- axis_clk  in  1  clock.
- axis_rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin; ignored while busy.
- data_length  in  32  sample count; sampled on accepted start.
- coef_idx  out  pIDX_WIDTH  index into the external coefficient store.
- coef_data  in  32  coefficient at coef_idx; combinational, valid in the same cycle.
- busy  out  1  high from accepted start until the done pulse.
- done  out  1  one-cycle pulse at the end of every run, successful or aborted.
- err  out  1  sticky error flag; cleared on the next accepted start.
- err_code  out  2  0 = none, 1 = readback mismatch, 2 = timeout, 3 = zero length.
- awvalid  out  1  write address valid.
- awaddr  out  pADDR_WIDTH  write address.
- awready  in  1  write address ready.
- wvalid  out  1  write data valid.
- wdata  out  pDATA_WIDTH  write data.
- wready  in  1  write data ready.
- arvalid  out  1  read address valid.
- araddr  out  pADDR_WIDTH  read address.
- arready  in  1  read address ready.
- rvalid  in  1  read data valid.
- rdata  in  pDATA_WIDTH  read data.
- rready  out  1  read data ready.

Behaviour:
- Reset (async, axis_rst=1):
  - State IDLE.
  - All valids, rready, busy, done, err, err_code, awaddr, wdata, araddr and coef_idx are 0.
  - Valid lines drop immediately, even mid-transaction.
- States: IDLE -> WR_LEN -> WR_COEF -> RD_COEF -> WR_START -> POLL_GAP -> POLL_RD -> FINISH -> IDLE.
- IDLE:
  - start=1 with data_length!=0: latch data_length, clear err/err_code, set busy, go to WR_LEN.
  - start=1 with data_length==0: err=1, err_code=3, go to FINISH with no bus traffic.
- Write transaction:
  - awvalid and wvalid rise in the same cycle, with awaddr/wdata stable until acceptance.
  - Each valid deasserts the cycle after its own ready is sampled high; awready and wready may arrive in any order or together.
  - The transaction completes when both handshakes have occurred.
- Read transaction:
  - arvalid is held until arready is sampled high.
  - rready rises with arvalid and stays high until rvalid is sampled high; rdata is captured on that edge.
- Spacing: at least one cycle with all valids low between consecutive transactions.
- WR_LEN: writes 0x10 <= latched data_length.
- WR_COEF: for k=0..Tape_Num-1, coef_idx=k and writes 0x20+k <= coef_data. Address step is +1, not +4.
- RD_COEF:
  - For k=0..Tape_Num-1, reads 0x20+k and compares the full 32 bits of rdata against coef_data at coef_idx=k.
  - First mismatch: err=1, err_code=1, go to FINISH; no ap_start is issued.
- WR_START: writes 0x00 <= 32'h0000_0001.
- POLL_GAP: waits pPOLL_GAP cycles with no bus activity.
- POLL_RD:
  - Reads 0x00.
  - rdata[1]=1 (ap_done): go to FINISH.
  - Otherwise: go back to POLL_GAP.
  - Polling is unbounded; the timeout applies per transaction only.
- Timeout:
  - The counter resets at each transaction start.
  - If a transaction stays outstanding for pTIMEOUT cycles: deassert all valids and rready, err=1, err_code=2, go to FINISH.
- FINISH: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- start during busy has no effect. start in the FINISH cycle is also ignored; the earliest re-accept is the following cycle.
- A coefficient of Tape_Num-1 is the last index; coef_idx holds its value after the loop ends (no wrap).

Test Plan:
- Normal run:
  - Stimulus: data_length=600; coefs 0,-10,-9,23,56,63,56,23,-9,-10,0; slave with zero-wait ready; ap_done asserted on the third poll.
  - Required: 13 writes in order (0x10=600, 0x20..0x2A, 0x00=1); 11 reads of 0x20..0x2A; 3 reads of 0x00 spaced by pPOLL_GAP; done pulse; err=0.
- Skewed write ready:
  - Stimulus: wready arrives at cycle 0, awready 3 cycles later.
  - Required: wvalid drops after 1 cycle, awvalid after 4; exactly one write is logged; the next transaction starts only after both handshakes.
- Readback mismatch:
  - Stimulus: slave returns 64 for 0x25.
  - Required: err=1, err_code=1, done pulse; no write to 0x00.
- Timeout:
  - Stimulus: arready held low during the read of 0x22; pTIMEOUT=1024.
  - Required: after 1024 cycles arvalid=0, err_code=2, done pulse.
- Zero length:
  - Stimulus: start with data_length=0.
  - Required: no valids asserted, err_code=3, done pulse on the cycle after start.
- Reset mid-operation:
  - Stimulus: assert axis_rst while awvalid=1 during WR_COEF k=5.
  - Required: all outputs 0 asynchronously; a new start afterwards re-runs from WR_LEN.
